// File: rtl/nw_pkg.sv
// Shared definitions for the NW score RAM datapath.
//   SCORE_W      - signed score width
//   score_t      - signed score type
//   rd_state_e   - score RAM reader FSM states
//   SLOT_*       - neighbour slot indices, in issue order
package nw_pkg;

    localparam int SCORE_W = 8;

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } rd_state_e;

    localparam logic [1:0] SLOT_DIAG = 2'd0;
    localparam logic [1:0] SLOT_UP   = 2'd1;
    localparam logic [1:0] SLOT_LEFT = 2'd2;

endpackage

// File: rtl/score_rd_phase_cnt.sv
// Slot phase counter for the score RAM reader: counts 0,1,2 while enabled, then wraps to 0.
//   clk, rst  - clock, asynchronous active-high reset
//   en        - advance the phase this cycle
//   phase     - current slot (SLOT_DIAG/SLOT_UP/SLOT_LEFT)
//   last      - high while enabled on the final slot (wraps at the next edge)
module score_rd_phase_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] phase,
    output logic       last
);
    import nw_pkg::*;

    logic [1:0] phase_q, phase_d;

    assign last  = en && (phase_q == SLOT_LEFT);
    assign phase = phase_q;

    always_comb begin
        phase_d = phase_q;
        if (en) begin
            phase_d = last ? SLOT_DIAG : phase_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= SLOT_DIAG;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/score_ram_reader.sv
// Read-side sequencer for the NW score RAM. For a request cell (i,j) it fetches the diag
// (i-1,j-1), up (i-1,j) and left (i,j-1) scores over one RAM read port and presents them
// via a valid/ready handshake. Row 0 and column 0 are synthesised as -k*GAP, never read.
// Fixed latency: request accepted in cycle 0, read slots in cycles 1-3, out_valid from cycle 5.
//   clk, rst                 - clock, asynchronous active-high reset
//   req_valid/req_ready      - request handshake, req_i/req_j cell row/column
//   ram_en/ram_addr          - RAM read port, ram_rdata valid the cycle after ram_en
//   out_valid/out_ready      - result handshake, diag/up/left signed scores
//   err                      - request out of range (i or j is 0 or exceeds N)
//   wr_en/wr_addr/wr_data    - writer snoop, present only with SCORE_RD_BYPASS_EN defined
// Optional feature macro: SCORE_RD_BYPASS_EN (capture same-cycle writes to an in-flight address).
module score_ram_reader #(
    parameter int N       = 8,
    parameter int IDX_W   = 4,
    parameter int ADDR_W  = 7,
    parameter int SCORE_W = nw_pkg::SCORE_W,
    parameter int GAP     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [IDX_W-1:0]          req_i,
    input  logic [IDX_W-1:0]          req_j,
    output logic                      ram_en,
    output logic [ADDR_W-1:0]         ram_addr,
    input  logic [SCORE_W-1:0]        ram_rdata,
`ifdef SCORE_RD_BYPASS_EN
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [SCORE_W-1:0]        wr_data,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [SCORE_W-1:0] diag,
    output logic signed [SCORE_W-1:0] up,
    output logic signed [SCORE_W-1:0] left,
    output logic                      err
);
    import nw_pkg::*;

    localparam int               COLS  = N + 1;
    localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N);

    // Boundary cell score: whichever of row/col is non-zero times -GAP; (0,0) gives 0.
    function automatic logic [SCORE_W-1:0] boundary_score(input logic [IDX_W-1:0] row,
                                                          input logic [IDX_W-1:0] col);
        logic [SCORE_W-1:0] k;
        k = (row == '0) ? SCORE_W'(col) : SCORE_W'(row);
        return SCORE_W'(0) - k * SCORE_W'(GAP);
    endfunction

    rd_state_e state_q, state_d;

    logic [IDX_W-1:0] i_q, j_q;
    logic             err_q;
    logic             accept;

    logic [1:0]       phase;
    logic             last;
    logic             issuing;

    logic [IDX_W-1:0]   nb_row, nb_col;
    logic               synth_slot;
    logic [SCORE_W-1:0] synth_val;
    logic [ADDR_W-1:0]  slot_addr;

    // Capture pipeline: describes the slot issued in the previous cycle.
    logic               cap_vld_q;
    logic [1:0]         cap_slot_q;
    logic               cap_synth_q;
    logic [SCORE_W-1:0] cap_val_q;
    logic [SCORE_W-1:0] cap_data;
`ifdef SCORE_RD_BYPASS_EN
    logic [ADDR_W-1:0]  cap_addr_q;
`endif

    logic signed [SCORE_W-1:0] diag_q, up_q, left_q;
    logic                      out_valid_q;

    score_rd_phase_cnt u_phase_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (issuing),
        .phase (phase),
        .last  (last)
    );

    assign issuing = (state_q == StIssue);
    assign accept  = req_valid && req_ready;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) state_d = StIssue;
            end
            StIssue: if (last) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Neighbour coordinates for the current slot.
    always_comb begin
        nb_row = i_q;
        nb_col = j_q;
        unique case (phase)
            SLOT_DIAG: begin
                nb_row = i_q - IDX_W'(1);
                nb_col = j_q - IDX_W'(1);
            end
            SLOT_UP: nb_row = i_q - IDX_W'(1);
            default: nb_col = j_q - IDX_W'(1);
        endcase
    end

    // Erroneous requests are forced onto the synthesised path so they never reach the address.
    assign synth_slot = err_q || (nb_row == '0) || (nb_col == '0);
    assign synth_val  = err_q ? '0 : boundary_score(nb_row, nb_col);
    assign slot_addr  = ADDR_W'(nb_row) * ADDR_W'(COLS) + ADDR_W'(nb_col);

    assign ram_en   = issuing && !synth_slot;
    assign ram_addr = ram_en ? slot_addr : '0;

    always_comb begin
        cap_data = cap_synth_q ? cap_val_q : ram_rdata;
`ifdef SCORE_RD_BYPASS_EN
        // Same-cycle write to the address being read: the RAM returns old data, take the new.
        if (!cap_synth_q && wr_en && (wr_addr == cap_addr_q)) cap_data = wr_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            i_q         <= '0;
            j_q         <= '0;
            err_q       <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_slot_q  <= SLOT_DIAG;
            cap_synth_q <= 1'b0;
            cap_val_q   <= '0;
`ifdef SCORE_RD_BYPASS_EN
            cap_addr_q  <= '0;
`endif
            diag_q      <= '0;
            up_q        <= '0;
            left_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_vld_q   <= issuing;
            cap_slot_q  <= phase;
            cap_synth_q <= synth_slot;
            cap_val_q   <= synth_val;
`ifdef SCORE_RD_BYPASS_EN
            cap_addr_q  <= ram_addr;
`endif
            if (accept) begin
                i_q   <= req_i;
                j_q   <= req_j;
                err_q <= (req_i == '0) || (req_j == '0) || (req_i > N_IDX) || (req_j > N_IDX);
            end
            if (cap_vld_q) begin
                unique case (cap_slot_q)
                    SLOT_DIAG: diag_q <= cap_data;
                    SLOT_UP:   up_q   <= cap_data;
                    default:   left_q <= cap_data;
                endcase
            end
            if (state_q == StDrain) begin
                out_valid_q <= 1'b1;
            end else if ((state_q == StDone) && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign diag      = diag_q;
    assign up        = up_q;
    assign left      = left_q;
    assign err       = err_q;

endmodule
